// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB receive path.
// Holds bit/byte sizing constants and the bit counter type.
package usb_rx_pkg;

   localparam int BITS_PER_BYTE        = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 8;
   localparam int MAX_ONES             = 6;

   typedef logic [$clog2(BITS_PER_BYTE)-1:0] bit_cnt_t;

endpackage

// File: rtl/flex_counter.sv
// Parameterized rollover counter with clear, restart and enable.
// Ports: clk, n_rst, clear (->0), restart (->1), count_enable,
//        rollover_val (last value before wrap to 0), count_out.
module flex_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             restart,
   input  logic             count_enable,
   input  logic [WIDTH-1:0] rollover_val,
   output logic [WIDTH-1:0] count_out
);

   logic [WIDTH-1:0] count_nxt;

   // restart treats the current cycle as count 0, so the
   // next value is 1 rather than 0
   always_comb begin
      count_nxt = count_out;
      if (clear) begin
         count_nxt = '0;
      end else if (restart) begin
         count_nxt = WIDTH'(1);
      end else if (count_enable) begin
         if (count_out == rollover_val) begin
            count_nxt = '0;
         end else begin
            count_nxt = count_out + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_out <= '0;
      end else begin
         count_out <= count_nxt;
      end
   end

endmodule

// File: rtl/rx_bit_timer.sv
// USB receive bit timing and bit unstuffing.
// Ports: clk, n_rst, rcving, d_edge, d_orig in; bit_tick,
//        shift_enable, byte_received, stuff_bit, stuff_error out.
module rx_bit_timer #(
   parameter int CLKS_PER_BIT = usb_rx_pkg::DEFAULT_CLKS_PER_BIT,
   parameter int SAMPLE_POINT = 3,
   parameter int MAX_ONES     = usb_rx_pkg::MAX_ONES
) (
   input  logic clk,
   input  logic n_rst,
   input  logic rcving,
   input  logic d_edge,
   input  logic d_orig,
   output logic bit_tick,
   output logic shift_enable,
   output logic byte_received,
   output logic stuff_bit,
   output logic stuff_error
);

   import usb_rx_pkg::*;

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int OW = $clog2(MAX_ONES + 1);

   localparam logic [CW-1:0] CLK_TOP  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] SAMPLE   = CW'(SAMPLE_POINT);
   localparam logic [OW-1:0] ONES_MAX = OW'(MAX_ONES);
   localparam bit_cnt_t      BIT_TOP  = bit_cnt_t'(BITS_PER_BYTE - 1);

   logic [CW-1:0] clk_cnt;
   bit_cnt_t      bit_cnt;
   logic [OW-1:0] ones_cnt;
   logic [OW-1:0] ones_nxt;
   logic          at_limit;
   logic          err_set;

   // Every d_plus transition re-centres the bit phase
   flex_counter #(
      .WIDTH(CW)
   ) u_clk_cnt (
      .clk         (clk),
      .n_rst       (n_rst),
      .clear       (!rcving),
      .restart     (d_edge),
      .count_enable(1'b1),
      .rollover_val(CLK_TOP),
      .count_out   (clk_cnt)
   );

   flex_counter #(
      .WIDTH($bits(bit_cnt_t))
   ) u_bit_cnt (
      .clk         (clk),
      .n_rst       (n_rst),
      .clear       (!rcving),
      .restart     (1'b0),
      .count_enable(shift_enable),
      .rollover_val(BIT_TOP),
      .count_out   (bit_cnt)
   );

   assign bit_tick = rcving && (clk_cnt == SAMPLE);
   assign at_limit = (ones_cnt == ONES_MAX);

   // A zero after MAX_ONES ones is a stuffed bit and is dropped;
   // a one at that point is a violation but still passed on
   always_comb begin
      shift_enable = 1'b0;
      stuff_bit    = 1'b0;
      err_set      = 1'b0;
      ones_nxt     = ones_cnt;
      if (bit_tick) begin
         unique case (1'b1)
            d_orig && !at_limit: begin
               shift_enable = 1'b1;
               ones_nxt     = ones_cnt + OW'(1);
            end
            d_orig && at_limit: begin
               shift_enable = 1'b1;
               err_set      = 1'b1;
            end
            !d_orig && at_limit: begin
               stuff_bit = 1'b1;
               ones_nxt  = '0;
            end
            default: begin
               shift_enable = 1'b1;
               ones_nxt     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ones_cnt      <= '0;
         byte_received <= 1'b0;
         stuff_error   <= 1'b0;
      end else begin
         byte_received <= shift_enable && (bit_cnt == BIT_TOP);
         if (!rcving) begin
            ones_cnt    <= '0;
            stuff_error <= 1'b0;
         end else begin
            ones_cnt <= ones_nxt;
            if (err_set) begin
               stuff_error <= 1'b1;
            end
         end
      end
   end

endmodule
